mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 83 ++++++++
 rtl/mem_lsu_align.sv | 18 +
 rtl/mem_lsu.sv | 196 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared opcode constants, FSM encoding and lane-select / store-replicate / load-extend helpers for the LSU.
package mem_lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_byte(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_SB};
    endfunction

    function automatic logic is_half(input logic [5:0] op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic is_word(input logic [5:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
    endfunction

    // Big-endian mirrors the byte offset: offset 0 lives in bits 31:24.
    function automatic logic [1:0] byte_lane(input logic [1:0] off, input logic be);
        return be ? ~off : off;
    endfunction

    function automatic logic half_hi(input logic [1:0] off, input logic be);
        return be ? ~off[1] : off[1];
    endfunction

    function automatic logic [3:0] lane_sel(input logic [5:0] op, input logic [1:0] off, input logic be);
        if (is_byte(op))
            return 4'b0001 << byte_lane(off, be);
        if (is_half(op))
            return half_hi(off, be) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] d);
        if (is_byte(op))
            return {4{d[7:0]}};
        if (is_half(op))
            return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [1:0] off,
                                                input logic be, input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sx;
        b  = data[{byte_lane(off, be), 3'b000} +: 8];
        h  = half_hi(off, be) ? data[31:16] : data[15:0];
        sx = (op == OP_LB) || (op == OP_LH);
        if (is_byte(op))
            return {{24{sx & b[7]}}, b};
        if (is_half(op))
            return {{16{sx & h[15]}}, h};
        return data;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Load-data aligner: picks the addressed lane(s) of the read word and sign/zero extends.
// Purely combinational, no flow control.
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [5:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    localparam logic BE = (BIG_ENDIAN != 0);

    assign data_o = load_extend(op_i, off_i, BE, data_i);

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: IDLE->WAIT->DONE bus FSM, result one cycle after ack (or after accept for non-memory/misaligned ops).
// Holds the pipeline via stall_o while a bus access is outstanding; gives up with buserr_o after TIMEOUT wait cycles.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [5:0]        aluop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              buserr_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i,
    input  logic              mem_ack_i
);

    localparam logic       BE      = (BIG_ENDIAN != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic              done_q, done_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              adel_q, adel_d;
    logic              ades_q, ades_d;
    logic              buserr_q, buserr_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [31:0]       load_data;

    mem_lsu_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .op_i   (op_q),
        .off_i  (off_q),
        .data_i (mem_data_i),
        .data_o (load_data)
    );

    assign stall_o = (state_q == ST_WAIT) ||
                     ((state_q == ST_IDLE) && valid_i &&
                      (is_load(aluop_i) || is_store(aluop_i)) &&
                      !misaligned(aluop_i, addr_i[1:0]));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        off_d      = off_q;
        done_d     = done_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        adel_d     = adel_q;
        ades_d     = ades_q;
        buserr_d   = buserr_q;
        mem_ce_d   = mem_ce_q;
        mem_we_d   = mem_we_q;
        mem_sel_d  = mem_sel_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    op_d    = aluop_i;
                    off_d   = addr_i[1:0];
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                    if (!(is_load(aluop_i) || is_store(aluop_i))) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (misaligned(aluop_i, addr_i[1:0])) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        adel_d  = is_load(aluop_i);
                        ades_d  = is_store(aluop_i);
                        wreg_d  = 1'b0;
                    end else begin
                        state_d    = ST_WAIT;
                        cnt_d      = 8'd0;
                        mem_ce_d   = 1'b1;
                        mem_we_d   = is_store(aluop_i);
                        mem_sel_d  = lane_sel(aluop_i, addr_i[1:0], BE);
                        mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
                        mem_data_d = store_data(aluop_i, reg2_i);
                    end
                end
            end
            ST_WAIT: begin
                // Ack is tested first so a same-cycle ack beats the timeout.
                if (mem_ack_i || (cnt_q == TO_LAST)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_ce_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_sel_d = 4'b0000;
                    if (mem_ack_i) begin
                        if (is_load(op_q))
                            wdata_d = load_data;
                    end else begin
                        buserr_d = 1'b1;
                        wreg_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                done_d   = 1'b0;
                wreg_d   = 1'b0;
                adel_d   = 1'b0;
                ades_d   = 1'b0;
                buserr_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            op_q       <= 6'd0;
            off_q      <= 2'd0;
            done_q     <= 1'b0;
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            wdata_q    <= 32'd0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
            buserr_q   <= 1'b0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_sel_q  <= 4'd0;
            mem_addr_q <= '0;
            mem_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            off_q      <= off_d;
            done_q     <= done_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
            buserr_q   <= buserr_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            mem_sel_q  <= mem_sel_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign done_o     = done_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign adel_o     = adel_q;
    assign ades_o     = ades_q;
    assign buserr_o   = buserr_q;
    assign mem_ce_o   = mem_ce_q;
    assign mem_we_o   = mem_we_q;
    assign mem_sel_o  = mem_sel_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench: big-endian and little-endian LSU instances share stimulus, both with TIMEOUT=4.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [5:0]  aluop_i = 6'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] reg2_i = 32'd0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] mem_data_i = 32'd0;
    logic        mem_ack_i = 1'b0;

    logic        b_stall, b_done, b_wreg, b_adel, b_ades, b_buserr, b_ce, b_we;
    logic [4:0]  b_wd;
    logic [31:0] b_wdata, b_addr, b_mdata;
    logic [3:0]  b_sel;
    logic        l_stall, l_done, l_wreg, l_adel, l_ades, l_buserr, l_ce, l_we;
    logic [4:0]  l_wd;
    logic [31:0] l_wdata, l_addr, l_mdata;
    logic [3:0]  l_sel;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LHU = 6'b100101;
    localparam logic [5:0] SH = 6'b101001, SW = 6'b101011, ADDU = 6'b000001;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(4)) u_be (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .addr_i(addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .stall_o(b_stall), .done_o(b_done), .wd_o(b_wd), .wreg_o(b_wreg), .wdata_o(b_wdata),
        .adel_o(b_adel), .ades_o(b_ades), .buserr_o(b_buserr),
        .mem_ce_o(b_ce), .mem_we_o(b_we), .mem_sel_o(b_sel), .mem_addr_o(b_addr),
        .mem_data_o(b_mdata), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    mem_lsu #(.ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(4)) u_le (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .addr_i(addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .stall_o(l_stall), .done_o(l_done), .wd_o(l_wd), .wreg_o(l_wreg), .wdata_o(l_wdata),
        .adel_o(l_adel), .ades_o(l_ades), .buserr_o(l_buserr),
        .mem_ce_o(l_ce), .mem_we_o(l_we), .mem_sel_o(l_sel), .mem_addr_o(l_addr),
        .mem_data_o(l_mdata), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] r2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdat);
        valid_i = 1'b1;
        aluop_i = op;
        addr_i  = addr;
        reg2_i  = r2;
        wd_i    = wd;
        wreg_i  = wreg;
        wdata_i = wdat;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        step();
        step();
        check("rst_done", 32'(b_done), 32'd0);
        check("rst_ce", 32'(b_ce), 32'd0);
        check("rst_stall", 32'(b_stall), 32'd0);
        check("rst_sel", 32'(b_sel), 32'd0);
        check("rst_wdata", b_wdata, 32'd0);
        rst = 1'b0;
        step();

        // LB at 0x103, big-endian, ack in second wait cycle
        drive(LB, 32'h103, 32'd0, 5'd7, 1'b1, 32'd0);
        check("lb_stall_idle", 32'(b_stall), 32'd1);
        step();
        valid_i = 1'b0;
        check("lb_ce", 32'(b_ce), 32'd1);
        check("lb_sel", 32'(b_sel), 32'b0001);
        check("lb_addr", b_addr, 32'h100);
        check("lb_we", 32'(b_we), 32'd0);
        check("lb_stall_wait", 32'(b_stall), 32'd1);
        step();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h112233F4;
        step();
        mem_ack_i = 1'b0;
        check("lb_done", 32'(b_done), 32'd1);
        check("lb_wdata", b_wdata, 32'hFFFFFFF4);
        check("lb_wreg", 32'(b_wreg), 32'd1);
        check("lb_wd", 32'(b_wd), 32'd7);
        check("lb_ce_off", 32'(b_ce), 32'd0);
        check("lb_sel_off", 32'(b_sel), 32'd0);
        step();
        check("lb_done_1cyc", 32'(b_done), 32'd0);

        // SH at 0x102: little-endian selects upper half, big-endian the lower
        drive(SH, 32'h102, 32'hAAAA5678, 5'd0, 1'b0, 32'd0);
        step();
        valid_i = 1'b0;
        check("sh_le_sel", 32'(l_sel), 32'b1100);
        check("sh_le_data", l_mdata, 32'h56785678);
        check("sh_le_we", 32'(l_we), 32'd1);
        check("sh_be_sel", 32'(b_sel), 32'b0011);
        step();
        check("sh_le_we_hold", 32'(l_we), 32'd1);
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        check("sh_le_we_drop", 32'(l_we), 32'd0);
        check("sh_le_done", 32'(l_done), 32'd1);
        step();

        // Misaligned LW
        drive(LW, 32'h101, 32'd0, 5'd4, 1'b1, 32'd0);
        check("lw_mis_stall", 32'(b_stall), 32'd0);
        step();
        valid_i = 1'b0;
        check("lw_mis_done", 32'(b_done), 32'd1);
        check("lw_mis_adel", 32'(b_adel), 32'd1);
        check("lw_mis_ades", 32'(b_ades), 32'd0);
        check("lw_mis_wreg", 32'(b_wreg), 32'd0);
        check("lw_mis_ce", 32'(b_ce), 32'd0);
        step();
        check("lw_mis_adel_clr", 32'(b_adel), 32'd0);
        check("lw_mis_ce2", 32'(b_ce), 32'd0);

        // Misaligned SH
        drive(SH, 32'h101, 32'd0, 5'd0, 1'b0, 32'd0);
        step();
        valid_i = 1'b0;
        check("sh_mis_ades", 32'(b_ades), 32'd1);
        check("sh_mis_adel", 32'(b_adel), 32'd0);
        step();

        // SW with no ack times out after 4 wait cycles
        drive(SW, 32'h200, 32'h01020304, 5'd0, 1'b0, 32'd0);
        step();
        valid_i = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && b_ce; i++) begin
            n++;
            if (b_done) check("to_done_early", 32'(b_done), 32'd0);
            step();
        end
        check("to_ce_cycles", n, 4);
        check("to_buserr", 32'(b_buserr), 32'd1);
        check("to_done", 32'(b_done), 32'd1);
        check("to_wreg", 32'(b_wreg), 32'd0);
        step();
        check("to_buserr_clr", 32'(b_buserr), 32'd0);

        // Ack on the final wait cycle wins over the timeout
        drive(LW, 32'h300, 32'd0, 5'd2, 1'b1, 32'd0);
        step();
        valid_i = 1'b0;
        step();
        step();
        step();
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hCAFEBABE;
        step();
        mem_ack_i = 1'b0;
        check("ackto_done", 32'(b_done), 32'd1);
        check("ackto_buserr", 32'(b_buserr), 32'd0);
        check("ackto_wdata", b_wdata, 32'hCAFEBABE);
        check("ackto_wreg", 32'(b_wreg), 32'd1);
        step();

        // LH sign extension in both endiannesses
        drive(LH, 32'h2, 32'd0, 5'd1, 1'b1, 32'd0);
        step();
        valid_i    = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h12348765;
        step();
        mem_ack_i = 1'b0;
        check("lh_be_wdata", b_wdata, 32'hFFFF8765);
        check("lh_le_wdata", l_wdata, 32'h00001234);
        step();

        // Non-memory op, then a request presented during DONE must wait
        drive(ADDU, 32'h0, 32'd0, 5'd3, 1'b1, 32'h12345678);
        check("alu_stall", 32'(b_stall), 32'd0);
        step();
        check("alu_done", 32'(b_done), 32'd1);
        check("alu_wdata", b_wdata, 32'h12345678);
        check("alu_wd", 32'(b_wd), 32'd3);
        drive(LW, 32'h40, 32'd0, 5'd5, 1'b1, 32'd0);
        check("done_stall", 32'(b_stall), 32'd0);
        step();
        check("done_no_accept", 32'(b_ce), 32'd0);
        check("done_1cyc", 32'(b_done), 32'd0);
        step();
        valid_i = 1'b0;
        check("idle_accept", 32'(b_ce), 32'd1);
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h0BADF00D;
        step();
        mem_ack_i = 1'b0;
        check("lw_wdata", b_wdata, 32'h0BADF00D);
        step();

        // Reset in the middle of a wait
        drive(LB, 32'h0, 32'd0, 5'd6, 1'b1, 32'd0);
        step();
        valid_i = 1'b0;
        check("rstw_ce_before", 32'(b_ce), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_ce", 32'(b_ce), 32'd0);
        check("rstw_sel", 32'(b_sel), 32'd0);
        check("rstw_stall", 32'(b_stall), 32'd0);
        check("rstw_wreg", 32'(b_wreg), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("rstw_no_done1", 32'(b_done), 32'd0);
        step();
        check("rstw_no_done2", 32'(b_done), 32'd0);

        drive(LHU, 32'h0, 32'd0, 5'd9, 1'b1, 32'd0);
        step();
        valid_i    = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'h8001FFFF;
        step();
        mem_ack_i = 1'b0;
        check("lhu_done", 32'(b_done), 32'd1);
        check("lhu_be_wdata", b_wdata, 32'h00008001);
        check("lhu_le_wdata", l_wdata, 32'h0000FFFF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
